sony_ir_ctrl: RTL and testbench

- Command controller placed between the SonyIR SIRC receiver and the CPU bus.
- Sequences the receiver: detects READY, captures DO and acknowledges each frame with a one-clock CS strobe.
- Debounces the remote's automatic frame repeats (~45 ms), flags held keys and key releases.
- Queues decoded events in a small FIFO that the CPU pops, and raises IRQ while events are pending.

---
 rtl/sony_ir_ctrl.sv | 133 +++++++++++++
 tb/tb_sony_ir_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sony_ir_ctrl.sv
// SIRC command controller: acknowledges SonyIR frames, debounces remote auto-repeats,
// flags held keys and key releases, and queues events in a small FIFO for the CPU.
module sony_ir_ctrl #(
  parameter int DEPTH      = 4,
  parameter int REPEAT_GAP = 6000,
  parameter int HOLD_COUNT = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CLK_10U,
  input  logic        IR_READY,
  input  logic [11:0] IR_DO,
  output logic        IR_CS,
  input  logic        RD,
  output logic [15:0] DO,
  output logic        AVAIL,
  output logic        IRQ
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(REPEAT_GAP + 1);

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_EVAL} state_t;

  state_t        state_q, state_d;
  logic [11:0]   code_q, code_d;
  logic [11:0]   last_q, last_d;
  logic [3:0]    rep_q, rep_d;
  logic          held_q, held_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          ovf_q, ovf_d;
  logic [AW:0]   wp_q, wp_d, rp_q, rp_d;
  logic [13:0]   mem [DEPTH];

  logic          gap_full, rel_fire;
  logic          push, push_ok, pop, empty, full;
  logic [13:0]   push_data, head;

  assign gap_full = (gap_q == GW'(REPEAT_GAP));
  // Release fires only on the tick that saturates the gap, so it is pushed exactly once.
  assign rel_fire = (state_q == S_IDLE) && held_q && CLK_10U && (gap_q == GW'(REPEAT_GAP - 1));

  assign empty   = (wp_q == rp_q);
  assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign pop     = RD && !empty;
  assign push_ok = push && (!full || pop);

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    last_d    = last_q;
    rep_d     = rep_q;
    held_d    = held_q;
    gap_d     = gap_q;
    push      = 1'b0;
    push_data = '0;
    if (CLK_10U && !gap_full) gap_d = gap_q + GW'(1);
    case (state_q)
      S_IDLE: begin
        if (rel_fire) begin
          push      = 1'b1;
          push_data = {2'b01, last_q};
          held_d    = 1'b0;
        end else if (IR_READY) begin
          code_d  = IR_DO;
          state_d = S_STROBE;
        end
      end
      S_STROBE: state_d = S_EVAL;
      S_EVAL: begin
        state_d = S_IDLE;
        gap_d   = '0;
        if (code_q != last_q || gap_full) begin
          push      = 1'b1;
          push_data = {2'b00, code_q};
          rep_d     = '0;
          held_d    = 1'b0;
          last_d    = code_q;
        end else if (rep_q != 4'hF) begin
          rep_d = rep_q + 4'd1;
          if (rep_d == 4'(HOLD_COUNT)) begin
            push      = 1'b1;
            push_data = {2'b10, code_q};
            held_d    = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pop is resolved before push, so a full FIFO read in the push cycle does not overflow.
  always_comb begin
    wp_d  = wp_q + {{AW{1'b0}}, push_ok};
    rp_d  = rp_q + {{AW{1'b0}}, pop};
    ovf_d = ovf_q;
    if (pop) ovf_d = 1'b0;
    if (push && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      last_q  <= '0;
      rep_q   <= '0;
      held_q  <= 1'b0;
      gap_q   <= GW'(REPEAT_GAP);
      ovf_q   <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      last_q  <= last_d;
      rep_q   <= rep_d;
      held_q  <= held_d;
      gap_q   <= gap_d;
      ovf_q   <= ovf_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && push_ok) mem[wp_q[AW-1:0]] <= push_data;
  end

  assign head  = mem[rp_q[AW-1:0]];
  assign DO    = empty ? 16'h0000 : {ovf_q, head[13:12], 1'b0, head[11:0]};
  assign AVAIL = !empty;
  assign IRQ   = AVAIL;
  assign IR_CS = (state_q == S_STROBE);
endmodule

// File: tb/tb_sony_ir_ctrl.sv
// Directed and randomized bench for sony_ir_ctrl; random phase is scored against an
// event-level model (elapsed ticks between frames, repeat counting, bounded queue).
module tb_sony_ir_ctrl;
  localparam int GAP   = 100;
  localparam int HOLD  = 2;
  localparam int DEPTH = 4;

  logic        CLK = 1'b0, RESET = 1'b1, CLK_10U = 1'b0, IR_READY = 1'b0, RD = 1'b0;
  logic [11:0] IR_DO = '0;
  logic        IR_CS, AVAIL, IRQ;
  logic [15:0] DO;

  sony_ir_ctrl #(.DEPTH(DEPTH), .REPEAT_GAP(GAP), .HOLD_COUNT(HOLD)) dut (
    .CLK(CLK), .RESET(RESET), .CLK_10U(CLK_10U), .IR_READY(IR_READY), .IR_DO(IR_DO),
    .IR_CS(IR_CS), .RD(RD), .DO(DO), .AVAIL(AVAIL), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  int tick_cnt = 0;
  int tdiv = 0;
  always @(negedge CLK) begin
    tdiv = (tdiv + 1) % 4;
    CLK_10U = (tdiv == 0);
    if (CLK_10U) tick_cnt++;
  end

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [13:0] mq[$];
  bit          m_ovf, m_held, m_fresh;
  logic [11:0] m_last;
  int          m_rep, m_last_t;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    mq.delete();
    m_ovf = 0; m_held = 0; m_fresh = 1; m_last = '0; m_rep = 0; m_last_t = 0;
  endtask

  task automatic m_push(input logic [13:0] e);
    if (mq.size() == DEPTH) m_ovf = 1;
    else mq.push_back(e);
  endtask

  task automatic m_frame(input logic [11:0] code);
    bit gone;
    gone = m_fresh || ((tick_cnt - m_last_t) >= GAP);
    if (m_held && gone) begin
      m_push({2'b01, m_last});
      m_held = 0;
    end
    if (code != m_last || gone) begin
      m_push({2'b00, code});
      m_rep = 0; m_held = 0; m_last = code;
    end else if (m_rep < 15) begin
      m_rep++;
      if (m_rep == HOLD) begin
        m_push({2'b10, code});
        m_held = 1;
      end
    end
    m_last_t = tick_cnt;
    m_fresh = 0;
  endtask

  task automatic m_silence();
    if (m_held) begin
      m_push({2'b01, m_last});
      m_held = 0;
    end
  endtask

  task automatic wait_ticks(input int n);
    int target;
    target = tick_cnt + n;
    while (tick_cnt < target) @(negedge CLK);
  endtask

  task automatic do_reset();
    IR_READY = 0; RD = 0; RESET = 1;
    repeat (2) @(negedge CLK);
    RESET = 0;
    m_reset();
  endtask

  // Sends one frame, holding READY until the strobe is seen; optional RD in the push cycle.
  task automatic send_frame(input logic [11:0] code, input bit rd_at_push, input logic [15:0] head_exp);
    int n;
    IR_DO = code; IR_READY = 1; n = 0;
    @(negedge CLK);
    while (IR_CS !== 1'b1 && n < 8) begin
      @(negedge CLK);
      n++;
    end
    check("cs_seen", 16'(IR_CS), 16'd1);
    IR_READY = 0; IR_DO = 12'($urandom);
    @(negedge CLK);
    check("cs_one_clk", 16'(IR_CS), 16'd0);
    if (rd_at_push) begin
      check("head_before_rd_push", DO, head_exp);
      RD = 1;
    end
    @(negedge CLK);
    RD = 0;
    m_frame(code);
  endtask

  task automatic pop_check(input string tag, input logic [15:0] exp);
    check({tag, "_avail"}, 16'(AVAIL), 16'd1);
    check(tag, DO, exp);
    RD = 1;
    @(negedge CLK);
    RD = 0;
  endtask

  task automatic drain_model(input string tag);
    logic [13:0] e;
    while (mq.size() > 0) begin
      e = mq.pop_front();
      pop_check(tag, {m_ovf, e[13:12], 1'b0, e[11:0]});
      m_ovf = 0;
    end
    check({tag, "_empty"}, 16'(AVAIL), 16'd0);
  endtask

  initial begin
    logic [11:0] code;
    RESET = 1;
    repeat (3) @(negedge CLK);
    RESET = 0;
    m_reset();
    check("rst_cs", 16'(IR_CS), 16'd0);
    check("rst_avail", 16'(AVAIL), 16'd0);
    check("rst_irq", 16'(IRQ), 16'd0);
    check("rst_do", DO, 16'h0000);

    // Single frame with exact strobe/push timing
    IR_DO = 12'h095; IR_READY = 1;
    @(negedge CLK);
    check("sf_cs_hi", 16'(IR_CS), 16'd1);
    IR_READY = 0;
    @(negedge CLK);
    check("sf_cs_lo", 16'(IR_CS), 16'd0);
    check("sf_avail_early", 16'(AVAIL), 16'd0);
    @(negedge CLK);
    check("sf_avail", 16'(AVAIL), 16'd1);
    check("sf_irq", 16'(IRQ), 16'd1);
    check("sf_do", DO, 16'h0095);
    RD = 1;
    @(negedge CLK);
    RD = 0;
    check("sf_avail_rd", 16'(AVAIL), 16'd0);
    check("sf_do_rd", DO, 16'h0000);
    RD = 1;
    @(negedge CLK);
    RD = 0;
    check("rd_empty_avail", 16'(AVAIL), 16'd0);

    // Hold: four frames 45 ticks apart, then silence
    wait_ticks(20);
    for (int i = 0; i < 4; i++) begin
      send_frame(12'h012, 0, 16'h0);
      if (i < 3) wait_ticks(45);
    end
    pop_check("hold_press", 16'h0012);
    pop_check("hold_held", 16'h4012);
    check("hold_only_two", 16'(AVAIL), 16'd0);
    wait_ticks(88);
    check("hold_no_rel_yet", 16'(AVAIL), 16'd0);
    wait_ticks(17);
    pop_check("hold_rel", 16'h2012);
    check("hold_after_rel", 16'(AVAIL), 16'd0);

    // Gap expiry
    send_frame(12'h012, 0, 16'h0);
    wait_ticks(150);
    send_frame(12'h012, 0, 16'h0);
    pop_check("gap_first", 16'h0012);
    pop_check("gap_second", 16'h0012);
    wait_ticks(110);
    check("gap_no_rel", 16'(AVAIL), 16'd0);

    // Code change
    send_frame(12'h001, 0, 16'h0);
    wait_ticks(10);
    send_frame(12'h002, 0, 16'h0);
    pop_check("chg_first", 16'h0001);
    pop_check("chg_second", 16'h0002);
    check("chg_empty", 16'(AVAIL), 16'd0);

    // Overflow
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      send_frame(12'h0A0 + 12'(i), 0, 16'h0);
      wait_ticks(10);
    end
    pop_check("ovf_head", 16'h80A1);
    pop_check("ovf_cleared", 16'h00A2);
    pop_check("ovf_3", 16'h00A3);
    pop_check("ovf_4", 16'h00A4);
    check("ovf_dropped", 16'(AVAIL), 16'd0);

    // Pop and push in the same cycle while full
    for (int i = 1; i <= 4; i++) begin
      send_frame(12'h0B0 + 12'(i), 0, 16'h0);
      wait_ticks(10);
    end
    send_frame(12'h0B5, 1, 16'h00B1);
    pop_check("pp_2", 16'h00B2);
    pop_check("pp_3", 16'h00B3);
    pop_check("pp_4", 16'h00B4);
    pop_check("pp_5", 16'h00B5);
    check("pp_count4", 16'(AVAIL), 16'd0);

    // Reset in the strobe cycle
    wait_ticks(10);
    IR_DO = 12'h03C; IR_READY = 1;
    @(negedge CLK);
    check("rm_strobe", 16'(IR_CS), 16'd1);
    RESET = 1; IR_READY = 0;
    @(negedge CLK);
    check("rm_cs", 16'(IR_CS), 16'd0);
    check("rm_avail", 16'(AVAIL), 16'd0);
    RESET = 0;
    m_reset();
    repeat (4) @(negedge CLK);
    check("rm_no_push", 16'(AVAIL), 16'd0);

    // Randomized frames scored against the model
    do_reset();
    code = 12'h001;
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 3) == 0) code = 12'($urandom_range(1, 3));
      send_frame(code, 0, 16'h0);
      drain_model("rnd");
      if ($urandom_range(0, 2) == 0) wait_ticks($urandom_range(130, 180));
      else wait_ticks($urandom_range(5, 60));
    end
    wait_ticks(115);
    m_silence();
    drain_model("rnd_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
